// File: rtl/wddl_dual_rail_decoder.sv
// WDDL dual-rail receiver: checks the precharge/evaluate protocol on true/false rail pairs
// and hands each completed evaluate word to a single-ended valid/ready consumer.
module wddl_dual_rail_decoder #(
  parameter int WIDTH     = 8,
  parameter int TMO_CYC   = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phase,
  input  logic [WIDTH-1:0]     dr_t,
  input  logic [WIDTH-1:0]     dr_f,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BOTH_HI = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    ST_PRE   = 2'd0,
    ST_EVAL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fell_q, fell_d;
  logic                 err_pulse_q;
  logic [1:0]           err_code_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic                 raise_err;
  logic [1:0]           raise_code;

  logic [WIDTH-1:0] done_bits;
  logic [WIDTH-1:0] bad_bits;
  logic             all_done;
  logic             any_bad;
  logic             rails_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rail
      assign done_bits[gi] = dr_t[gi] ^ dr_f[gi];
      assign bad_bits[gi]  = dr_t[gi] & dr_f[gi];
    end
  endgenerate

  assign all_done   = &done_bits;
  assign any_bad    = |bad_bits;
  assign rails_zero = ~|(dr_t | dr_f);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fell_d     = fell_q;
    raise_err  = 1'b0;
    raise_code = ERR_NONE;

    unique case (state_q)
      ST_PRE: begin
        if (phase) begin
          state_d = ST_EVAL;
          tmo_d   = '0;
        end
      end

      ST_EVAL: begin
        // Priority order: bad rail > complete word > early precharge > timeout.
        if (any_bad) begin
          raise_err  = 1'b1;
          raise_code = ERR_BOTH_HI;
          state_d    = ST_DRAIN;
        end else if (all_done) begin
          data_d  = dr_t;
          valid_d = 1'b1;
          fell_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (!phase) begin
          raise_err  = 1'b1;
          raise_code = ERR_TIMEOUT;
          state_d    = ST_PRE;
        end else if (tmo_q == TMO_LAST) begin
          raise_err  = 1'b1;
          raise_code = ERR_TIMEOUT;
          state_d    = ST_DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_HOLD: begin
        // A full precharge-then-evaluate while still holding means the next word is lost.
        if (!phase) begin
          fell_d = 1'b1;
        end else if (fell_q) begin
          raise_err  = 1'b1;
          raise_code = ERR_OVERRUN;
          fell_d     = 1'b0;
        end
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          fell_d  = 1'b0;
          state_d = phase ? ST_DRAIN : ST_PRE;
        end
      end

      ST_DRAIN: begin
        if (!phase && rails_zero) begin
          state_d = ST_PRE;
        end
      end

      default: state_d = ST_PRE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRE;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fell_q  <= fell_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= raise_err;
      if (raise_err) begin
        err_code_q <= raise_code;
        if (err_count_q != {ERR_CNT_W{1'b1}}) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_wddl_dual_rail_decoder.sv
// Directed bench for the WDDL dual-rail decoder; accepted words are checked against a
// queue of expected words filled when each complete evaluate word is driven.
module tb_wddl_dual_rail_decoder;

  logic       clk;
  logic       rst_n;
  logic       phase;
  logic [7:0] dr_t;
  logic [7:0] dr_f;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;

  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_q[$];

  wddl_dual_rail_decoder #(
    .WIDTH    (8),
    .TMO_CYC  (4),
    .ERR_CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase    (phase),
    .dr_t     (dr_t),
    .dr_f     (dr_f),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ph, input logic [7:0] t, input logic [7:0] f, input logic rdy);
    phase     = ph;
    dr_t      = t;
    dr_f      = f;
    out_ready = rdy;
  endtask

  // Scores any handshake that happens at the coming edge, then advances one cycle.
  task automatic step();
    logic [7:0] w;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_word", {24'd0, out_data}, {24'd0, w});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input string tag, input logic [7:0] t, input logic [7:0] f);
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    step();
    exp_q.push_back(t);
    drive(1'b1, t, f, 1'b1);
    step();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, t});
    chk({tag, "_noerr"}, {31'd0, err_pulse}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    step();
    chk({tag, "_cleared"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: clean A5 word, valid one cycle after completion, accepted immediately
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    step();
    chk("t1_pre_valid", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(8'hA5);
    drive(1'b1, 8'hA5, 8'h5A, 1'b1);
    step();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {24'd0, out_data}, 32'hA5);
    chk("t1_noerr", {31'd0, err_pulse}, 32'd0);
    step();
    chk("t1_drop_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    step();
    chk("t1_count", {24'd0, err_count}, 32'd0);

    // 2: both rails high on bit 0
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    step();
    drive(1'b1, 8'hFF, 8'h01, 1'b1);
    step();
    chk("t2_pulse", {31'd0, err_pulse}, 32'd1);
    chk("t2_code", {30'd0, err_code}, 32'd1);
    chk("t2_count", {24'd0, err_count}, 32'd1);
    chk("t2_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    step();
    chk("t2_pulse_end", {31'd0, err_pulse}, 32'd0);
    chk("t2_code_hold", {30'd0, err_code}, 32'd1);

    // 3: bit 3 never evaluates -> timeout after 4 evaluate cycles
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    step();
    drive(1'b1, 8'hF7, 8'h00, 1'b1);
    repeat (3) step();
    chk("t3_no_early", {31'd0, err_pulse}, 32'd0);
    step();
    chk("t3_pulse", {31'd0, err_pulse}, 32'd1);
    chk("t3_code", {30'd0, err_code}, 32'd2);
    chk("t3_count", {24'd0, err_count}, 32'd2);
    drive(1'b1, 8'hF7, 8'h08, 1'b1);
    step();
    chk("t3_drain_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    step();
    run_word("t3_recover", 8'h3C, 8'hC3);

    // 4: consumer stalls across a second full wave -> overrun, first word kept
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    step();
    exp_q.push_back(8'h11);
    drive(1'b1, 8'h11, 8'hEE, 1'b0);
    step();
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk("t4_fall_noerr", {31'd0, err_pulse}, 32'd0);
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    step();
    chk("t4_pulse", {31'd0, err_pulse}, 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd3);
    chk("t4_count", {24'd0, err_count}, 32'd3);
    drive(1'b1, 8'h22, 8'hDD, 1'b0);
    step();
    chk("t4_data_kept", {24'd0, out_data}, 32'h11);
    chk("t4_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("t4_pulse_end", {31'd0, err_pulse}, 32'd0);
    drive(1'b1, 8'h22, 8'hDD, 1'b1);
    step();
    chk("t4_accepted", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    step();

    // 5: 300 both-rails errors saturate the counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      step();
      drive(1'b1, 8'hFF, 8'hFF, 1'b1);
      step();
      if (i == 250) chk("t5_count_254", {24'd0, err_count}, 32'd254);
      if (i == 299) chk("t5_last_pulse", {31'd0, err_pulse}, 32'd1);
      drive(1'b0, 8'h00, 8'h00, 1'b1);
      step();
    end
    chk("t5_saturated", {24'd0, err_count}, 32'd255);

    // 6: asynchronous reset while a word is held
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h5A, 8'hA5, 1'b0);
    step();
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_data", {24'd0, out_data}, 32'd0);
    chk("t6_async_count", {24'd0, err_count}, 32'd0);
    chk("t6_async_code", {30'd0, err_code}, 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_word("t6_after", 8'hC3, 8'h3C);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
